// File: rtl/multdiv_pkg.sv
// Shared constants, state encoding, result payload and helpers for the
// sequenced multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned ITERS   = 32;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned BOOTH_W = 2 * WIDTH + 1;
    localparam int unsigned DIV_W   = 2 * WIDTH;

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic             exception;
        logic [WIDTH-1:0] value;
    } md_result_t;

    // Two's-complement magnitude; INT_MIN maps to itself read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter with synchronous clear/enable and a terminal-count flag.
module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign terminal_c = (count_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/alu_multdiv_ctrl.sv
// Sequenced signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit
// that sits beside the single-cycle ALU; the core stalls while busy.
module alu_multdiv_ctrl
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    logic [1:0]         state_q, state_nxt;
    logic               load_mult, load_div, cnt_clear, cnt_en, finish;
    logic               cnt_term_c;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   dvs_mag;
    logic [BOOTH_W-1:0] booth_q, booth_nxt;
    logic [DIV_W-1:0]   div_q, div_nxt;
    logic [WIDTH:0]     booth_acc, booth_a, booth_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [DIV_W-1:0]   product;
    logic [WIDTH:0]     product_top;
    logic [WIDTH-1:0]   quotient;
    md_result_t         result_c;

    multdiv_counter u_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (cnt_clear),
        .enable     (cnt_en),
        .terminal_c (cnt_term_c)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // DONE also accepts a start so a new op can issue on the edge after RDY.
    always_comb begin
        state_nxt = state_q;
        load_mult = 1'b0;
        load_div  = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                cnt_clear = 1'b1;
                if (ctrl_MULT) begin
                    state_nxt = ST_MULT;
                    load_mult = 1'b1;
                end else if (ctrl_DIV) begin
                    state_nxt = ST_DIV;
                    load_div  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MULT, ST_DIV: begin
                cnt_en = 1'b1;
                if (cnt_term_c) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Booth step: 33-bit signed add/sub keeps INT_MIN operands exact.
    always_comb begin
        booth_acc = {booth_q[BOOTH_W-1], booth_q[BOOTH_W-1 -: WIDTH]};
        booth_a   = {a_q[WIDTH-1], a_q};
        case (booth_q[1:0])
            2'b10:   booth_sum = booth_acc - booth_a;
            2'b01:   booth_sum = booth_acc + booth_a;
            default: booth_sum = booth_acc;
        endcase
        booth_nxt = {booth_sum, booth_q[WIDTH:1]};
    end

    assign dvs_mag = magnitude(b_q);

    // Restoring step on magnitudes: shift, trial-subtract, keep or restore.
    always_comb begin
        div_shift = div_q[DIV_W-1:WIDTH-1];
        div_trial = div_shift - {1'b0, dvs_mag};
        if (div_trial[WIDTH]) begin
            div_nxt = {div_shift[WIDTH-1:0], div_q[WIDTH-2:0], 1'b0};
        end else begin
            div_nxt = {div_trial[WIDTH-1:0], div_q[WIDTH-2:0], 1'b1};
        end
    end

    assign product     = booth_nxt[BOOTH_W-1:1];
    assign product_top = product[DIV_W-1:WIDTH-1];
    assign quotient    = div_nxt[WIDTH-1:0];

    // Final result, valid on the edge that leaves MULT/DIV.
    always_comb begin
        result_c = '0;
        if (state_q == ST_MULT) begin
            result_c.value     = product[WIDTH-1:0];
            result_c.exception = ~((&product_top) | (~|product_top));
        end else if (b_q == '0) begin
            result_c.value     = '0;
            result_c.exception = 1'b1;
        end else if ((a_q == INT_MIN) && (b_q == '1)) begin
            result_c.value     = INT_MIN;
            result_c.exception = 1'b1;
        end else if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
            result_c.value     = ~quotient + WIDTH'(1);
        end else begin
            result_c.value     = quotient;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            booth_q <= '0;
            div_q   <= '0;
        end else begin
            if (load_mult || load_div) begin
                a_q <= data_operandA;
                b_q <= data_operandB;
            end
            if (load_mult) begin
                booth_q <= {WIDTH'(0), data_operandB, 1'b0};
            end else if (state_q == ST_MULT) begin
                booth_q <= booth_nxt;
            end
            if (load_div) begin
                div_q <= {WIDTH'(0), magnitude(data_operandA)};
            end else if (state_q == ST_DIV) begin
                div_q <= div_nxt;
            end
        end
    end

    // Registered outputs; result/exception hold until the next DONE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= (state_nxt == ST_DONE);
            busy           <= (state_nxt != ST_IDLE);
            if (finish) begin
                data_result    <= result_c.value;
                data_exception <= result_c.exception;
            end
        end
    end

endmodule

// File: tb/tb_alu_multdiv_ctrl.sv
// Scoreboard bench for alu_multdiv_ctrl: expected results are queued at start
// and popped when the ready strobe appears.
module tb_alu_multdiv_ctrl;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int   passed;
    int   total;
    exp_t exp_q[$];

    alu_multdiv_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input bit mult, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        int     sa;
        int     sb;
        if (mult) begin
            p     = longint'(signed'(a)) * longint'(signed'(b));
            e.res = p[31:0];
            e.exc = (p != longint'(signed'(p[31:0])));
        end else begin
            sa = signed'(a);
            sb = signed'(b);
            if (sb == 0) begin
                e.res = 32'h0;
                e.exc = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.res = 32'h8000_0000;
                e.exc = 1'b1;
            end else begin
                e.res = 32'(sa / sb);
                e.exc = 1'b0;
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_op(input bit mult, input bit div, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mult;
        ctrl_DIV      = div;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int n, output bit seen);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 60) begin
            @(posedge clock);
            @(negedge clock);
            n++;
            if (data_resultRDY === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (data_result !== 32'h0) $display("FAIL reset result: got %h want 00000000", data_result); else passed++;
        total++; if (data_exception !== 1'b0) $display("FAIL reset exception: got %b want 0", data_exception); else passed++;
        total++; if (data_resultRDY !== 1'b0) $display("FAIL reset rdy: got %b want 0", data_resultRDY); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
        reset_n = 1'b1;
        repeat (2) begin @(posedge clock); @(negedge clock); end
        total++; if (busy !== 1'b0 || data_resultRDY !== 1'b0)
            $display("FAIL idle after reset: busy=%b rdy=%b want 0 0", busy, data_resultRDY); else passed++;
    endtask

    task automatic test_mult();
        logic [31:0] ta [0:5];
        logic [31:0] tb [0:5];
        exp_t        e;
        int          n;
        bit          seen;
        ta = '{32'd7, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tb = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(model(1'b1, ta[i], tb[i]));
            start_op(1'b1, 1'b0, ta[i], tb[i]);
            if (i == 0) begin
                total++; if (busy !== 1'b1) $display("FAIL mult busy after start: got %b want 1", busy); else passed++;
            end
            wait_rdy(n, seen);
            e = exp_q.pop_front();
            total++; if (!seen || n != 32) $display("FAIL mult%0d latency: got %0d (seen=%0b) want 32", i, n, seen); else passed++;
            total++; if (data_result !== e.res) $display("FAIL mult%0d result: got %h want %h", i, data_result, e.res); else passed++;
            total++; if (data_exception !== e.exc) $display("FAIL mult%0d exception: got %b want %b", i, data_exception, e.exc); else passed++;
            if (i == 0) begin
                @(posedge clock);
                @(negedge clock);
                total++; if (busy !== 1'b0 || data_resultRDY !== 1'b0)
                    $display("FAIL mult after done: busy=%b rdy=%b want 0 0", busy, data_resultRDY); else passed++;
                total++; if (data_result !== 32'hFFFF_FFD6) $display("FAIL mult hold: got %h want ffffffd6", data_result); else passed++;
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] ta [0:8];
        logic [31:0] tb [0:8];
        exp_t        e;
        int          n;
        bit          seen;
        ta = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C,
               32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        tb = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9,
               32'hFFFF_FF9C, 32'd1, 32'd2, 32'h8000_0000};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(model(1'b0, ta[i], tb[i]));
            start_op(1'b0, 1'b1, ta[i], tb[i]);
            wait_rdy(n, seen);
            e = exp_q.pop_front();
            total++; if (!seen || n != 32) $display("FAIL div%0d latency: got %0d (seen=%0b) want 32", i, n, seen); else passed++;
            total++; if (data_result !== e.res) $display("FAIL div%0d result: got %h want %h", i, data_result, e.res); else passed++;
            total++; if (data_exception !== e.exc) $display("FAIL div%0d exception: got %b want %b", i, data_exception, e.exc); else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        bit          mult;
        exp_t        e;
        int          n;
        bit          seen;
        for (int i = 0; i < 12; i++) begin
            mult = i[0];
            a    = $urandom;
            b    = (!mult && i[1]) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
            if (mult && i[2]) a = 32'($signed($urandom_range(0, 60000)) - 30000);
            exp_q.push_back(model(mult, a, b));
            start_op(mult, !mult, a, b);
            wait_rdy(n, seen);
            e = exp_q.pop_front();
            total++; if (!seen) $display("FAIL rand%0d rdy: not seen within %0d cycles", i, n); else passed++;
            total++; if (data_result !== e.res || data_exception !== e.exc)
                $display("FAIL rand%0d %s %h,%h: got %h/%b want %h/%b", i, mult ? "mult" : "div", a, b,
                         data_result, data_exception, e.res, e.exc); else passed++;
        end
    endtask

    task automatic test_priority_busy();
        exp_t e;
        int   rdy_cnt;
        int   first_c;
        exp_q.push_back(model(1'b1, 32'd6, 32'd3));
        data_operandA = 32'd6;
        data_operandB = 32'd3;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        rdy_cnt   = 0;
        first_c   = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 10) begin
                data_operandA = 32'd99;
                data_operandB = 32'd4;
                ctrl_DIV      = 1'b1;
            end
            @(posedge clock);
            @(negedge clock);
            ctrl_DIV = 1'b0;
            if (data_resultRDY === 1'b1) begin
                rdy_cnt++;
                if (rdy_cnt == 1) begin
                    first_c = c;
                    e = exp_q.pop_front();
                    total++; if (data_result !== e.res || data_exception !== e.exc)
                        $display("FAIL priority result: got %h/%b want %h/%b", data_result, data_exception, e.res, e.exc);
                    else passed++;
                end
            end
        end
        total++; if (rdy_cnt != 1) $display("FAIL busy ignore rdy count: got %0d want 1", rdy_cnt); else passed++;
        total++; if (first_c != 32) $display("FAIL priority latency: got %0d want 32", first_c); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL busy ignore final busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   rdy_cnt;
        int   n;
        bit   seen;
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (14) begin @(posedge clock); @(negedge clock); end
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        total++; if (data_result !== 32'h0) $display("FAIL midreset result: got %h want 00000000", data_result); else passed++;
        total++; if (data_exception !== 1'b0) $display("FAIL midreset exception: got %b want 0", data_exception); else passed++;
        total++; if (data_resultRDY !== 1'b0) $display("FAIL midreset rdy: got %b want 0", data_resultRDY); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midreset busy: got %b want 0", busy); else passed++;
        reset_n = 1'b1;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_cnt++;
        end
        total++; if (rdy_cnt != 0) $display("FAIL midreset stray rdy: got %0d want 0", rdy_cnt); else passed++;
        exp_q.push_back(model(1'b0, 32'd100, 32'd7));
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        wait_rdy(n, seen);
        e = exp_q.pop_front();
        total++; if (!seen || n != 32) $display("FAIL postreset latency: got %0d (seen=%0b) want 32", n, seen); else passed++;
        total++; if (data_result !== e.res || data_exception !== e.exc)
            $display("FAIL postreset div: got %h/%b want %h/%b", data_result, data_exception, e.res, e.exc); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        bit   seen;
        exp_q.push_back(model(1'b1, 32'd6, 32'd7));
        start_op(1'b1, 1'b0, 32'd6, 32'd7);
        wait_rdy(n, seen);
        e = exp_q.pop_front();
        total++; if (!seen || data_result !== e.res) $display("FAIL b2b first: got %h want %h", data_result, e.res); else passed++;
        exp_q.push_back(model(1'b1, 32'd3, 32'd5));
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        total++; if (busy !== 1'b1 || data_resultRDY !== 1'b0)
            $display("FAIL b2b accept: busy=%b rdy=%b want 1 0", busy, data_resultRDY); else passed++;
        wait_rdy(n, seen);
        e = exp_q.pop_front();
        total++; if (!seen || n != 32) $display("FAIL b2b latency: got %0d (seen=%0b) want 32", n, seen); else passed++;
        total++; if (data_result !== e.res || data_exception !== e.exc)
            $display("FAIL b2b second: got %h/%b want %h/%b", data_result, data_exception, e.res, e.exc); else passed++;
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_priority_busy();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
